// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding, field positions and opcodes.
// Consumed by the fetch queue and its FIFO storage.
package cpu_pkg;

    localparam int IW = 8;
    localparam logic [7:0] NOP = 8'h00;

    localparam int MODE_BIT   = 7;
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 4;
    localparam int RD_MSB     = 3;
    localparam int RD_LSB     = 2;
    localparam int RS_MSB     = 1;
    localparam int RS_LSB     = 0;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_INC = 3'b011;

    typedef enum logic [1:0] {
        ISSUE_HOLD,
        ISSUE_BYPASS,
        ISSUE_HEAD,
        ISSUE_BUBBLE
    } issue_sel_e;

    function automatic logic [2:0] opcodeOf(input logic [7:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction storage with read/write pointers and occupancy count.
// A write while full is accepted only if a read frees the slot in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [IW-1:0] i_din,
    output logic [IW-1:0] o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [IW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_wrEn;
    logic          w_rdEn;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rdPtr];

    assign w_rdEn = i_pop & ~o_empty;
    assign w_wrEn = i_push & (~o_full | w_rdEn);

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdEn) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wrEn, w_rdEn})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue top: load-key edge detect, issue register, pc and sticky overflow.
// Define FETCH_BYPASS_EN to let a push into an empty, unstalled queue issue on the same edge.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = cpu_pkg::IW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [IW-1:0] instr_in,
    input  logic          stall,
    output logic [IW-1:0] if_id_reg,
    output logic          if_id_valid,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    pc,
    output logic          overflow
);

    logic          r_loadQ;
    logic          w_push;
    logic          w_popReq;
    logic          w_bypass;
    logic          w_fifoPush;
    logic [IW-1:0] w_head;
    issue_sel_e    w_issueSel;

    assign w_push   = load & ~r_loadQ;
    assign w_popReq = ~stall & ~empty;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_push & empty & ~stall;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifoPush = w_push & ~w_bypass;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_fifoPush),
        .i_pop   (w_popReq),
        .i_din   (instr_in),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    always_comb begin
        w_issueSel = ISSUE_HOLD;
        if (!stall) begin
            if (w_bypass) begin
                w_issueSel = ISSUE_BYPASS;
            end else if (!empty) begin
                w_issueSel = ISSUE_HEAD;
            end else begin
                w_issueSel = ISSUE_BUBBLE;
            end
        end
    end

    // When full, a pop happens exactly when not stalled, so only a stalled full push is lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_loadQ     <= 1'b0;
            if_id_reg   <= IW'(NOP);
            if_id_valid <= 1'b0;
            pc          <= 8'h00;
            overflow    <= 1'b0;
        end else begin
            r_loadQ <= load;
            if (w_push && full && !w_popReq) begin
                overflow <= 1'b1;
            end
            case (w_issueSel)
                ISSUE_BYPASS: begin
                    if_id_reg   <= instr_in;
                    if_id_valid <= 1'b1;
                    pc          <= pc + 8'd1;
                end
                ISSUE_HEAD: begin
                    if_id_reg   <= w_head;
                    if_id_valid <= 1'b1;
                    pc          <= pc + 8'd1;
                end
                ISSUE_BUBBLE: begin
                    if_id_reg   <= IW'(NOP);
                    if_id_valid <= 1'b0;
                end
                default: begin
                    if_id_reg   <= if_id_reg;
                    if_id_valid <= if_id_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, IW=8).
// Expectations adapt to FETCH_BYPASS_EN when the design is built with it.
module tb_instr_fetch_queue;

    logic       clk;
    logic       resetn;
    logic       load;
    logic [7:0] instr_in;
    logic       stall;
    logic [7:0] if_id_reg;
    logic       if_id_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic [7:0] pc;
    logic       overflow;

    int passCount;
    int checkCount;

    instr_fetch_queue #(
        .DEPTH (4),
        .IW    (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .instr_in    (instr_in),
        .stall       (stall),
        .if_id_reg   (if_id_reg),
        .if_id_valid (if_id_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .pc          (pc),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyReset();
        resetn   = 1'b0;
        load     = 1'b0;
        stall    = 1'b0;
        instr_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic pushInstr(input logic [7:0] v);
        instr_in = v;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        load = 1'b0; stall = 1'b0; instr_in = 8'h00;
        #1;
        checkCount++; if (if_id_reg !== 8'h00) $display("[TB] FAIL reset_reg: got %h want 00", if_id_reg); else passCount++;
        checkCount++; if (if_id_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", if_id_valid); else passCount++;
        checkCount++; if (pc !== 8'h00) $display("[TB] FAIL reset_pc: got %h want 00", pc); else passCount++;
        checkCount++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else passCount++;
        checkCount++; if (empty !== 1'b1 || full !== 1'b0) $display("[TB] FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b want 0", overflow); else passCount++;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_issue();
        applyReset();
        instr_in = 8'h1D;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
`ifdef FETCH_BYPASS_EN
        checkCount++; if (if_id_reg !== 8'h1D || if_id_valid !== 1'b1) $display("[TB] FAIL single_bypass_issue: got %h/%b want 1d/1", if_id_reg, if_id_valid); else passCount++;
        checkCount++; if (count !== 3'd0 || pc !== 8'd1) $display("[TB] FAIL single_bypass_state: got count=%0d pc=%0d want 0/1", count, pc); else passCount++;
        @(negedge clk);
        checkCount++; if (if_id_reg !== 8'h00 || if_id_valid !== 1'b0) $display("[TB] FAIL single_bubble: got %h/%b want 00/0", if_id_reg, if_id_valid); else passCount++;
`else
        checkCount++; if (if_id_valid !== 1'b0 || count !== 3'd1) $display("[TB] FAIL single_push_edge: got valid=%b count=%0d want 0/1", if_id_valid, count); else passCount++;
        @(negedge clk);
        checkCount++; if (if_id_reg !== 8'h1D || if_id_valid !== 1'b1) $display("[TB] FAIL single_issue: got %h/%b want 1d/1", if_id_reg, if_id_valid); else passCount++;
        checkCount++; if (pc !== 8'd1 || empty !== 1'b1) $display("[TB] FAIL single_pc: got pc=%0d empty=%b want 1/1", pc, empty); else passCount++;
`endif
        @(negedge clk);
        checkCount++; if (if_id_valid !== 1'b0 || pc !== 8'd1) $display("[TB] FAIL single_after: got valid=%b pc=%0d want 0/1", if_id_valid, pc); else passCount++;
    endtask

    task automatic test_fill_drain();
        logic [7:0] expVals [4];
        expVals = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyReset();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) pushInstr(expVals[k]);
        checkCount++; if (full !== 1'b1 || count !== 3'd4) $display("[TB] FAIL fill_full: got full=%b count=%0d want 1/4", full, count); else passCount++;
        checkCount++; if (if_id_valid !== 1'b0 || pc !== 8'd0) $display("[TB] FAIL fill_stalled: got valid=%b pc=%0d want 0/0", if_id_valid, pc); else passCount++;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkCount++; if (if_id_reg !== expVals[k] || if_id_valid !== 1'b1) $display("[TB] FAIL drain_%0d: got %h/%b want %h/1", k, if_id_reg, if_id_valid, expVals[k]); else passCount++;
        end
        @(negedge clk);
        checkCount++; if (if_id_reg !== 8'h00 || if_id_valid !== 1'b0) $display("[TB] FAIL drain_nop: got %h/%b want 00/0", if_id_reg, if_id_valid); else passCount++;
        checkCount++; if (pc !== 8'd4 || empty !== 1'b1) $display("[TB] FAIL drain_pc: got pc=%0d empty=%b want 4/1", pc, empty); else passCount++;
    endtask

    task automatic test_overflow();
        logic [7:0] expVals [4];
        expVals = '{8'h22, 8'h33, 8'h44, 8'h66};
        applyReset();
        stall = 1'b1;
        pushInstr(8'h11); pushInstr(8'h22); pushInstr(8'h33); pushInstr(8'h44);
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_before: got %b want 0", overflow); else passCount++;
        pushInstr(8'h55);
        checkCount++; if (overflow !== 1'b1 || count !== 3'd4) $display("[TB] FAIL ovf_drop: got ovf=%b count=%0d want 1/4", overflow, count); else passCount++;
        stall = 1'b0; instr_in = 8'h66; load = 1'b1;
        @(negedge clk);
        stall = 1'b1; load = 1'b0;
        checkCount++; if (if_id_reg !== 8'h11 || count !== 3'd4) $display("[TB] FAIL ovf_pushpop: got reg=%h count=%0d want 11/4", if_id_reg, count); else passCount++;
        @(negedge clk);
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkCount++; if (if_id_reg !== expVals[k] || if_id_valid !== 1'b1) $display("[TB] FAIL ovf_order_%0d: got %h/%b want %h/1", k, if_id_reg, if_id_valid, expVals[k]); else passCount++;
        end
        checkCount++; if (overflow !== 1'b1 || pc !== 8'd5) $display("[TB] FAIL ovf_sticky: got ovf=%b pc=%0d want 1/5", overflow, pc); else passCount++;
    endtask

    task automatic test_held_load();
        applyReset();
        stall = 1'b1; instr_in = 8'h5A; load = 1'b1;
        repeat (10) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checkCount++; if (count !== 3'd1) $display("[TB] FAIL held_count: got %0d want 1", count); else passCount++;
        stall = 1'b0;
        @(negedge clk);
        checkCount++; if (if_id_reg !== 8'h5A || count !== 3'd0) $display("[TB] FAIL held_issue: got reg=%h count=%0d want 5a/0", if_id_reg, count); else passCount++;
    endtask

    task automatic test_pc_wrap();
        int orderErrors;
        orderErrors = 0;
        applyReset();
        for (int i = 0; i < 256; i++) begin
            instr_in = 8'(i);
            load     = 1'b1;
            @(negedge clk);
            load = 1'b0;
`ifdef FETCH_BYPASS_EN
            if (if_id_reg !== 8'(i) || if_id_valid !== 1'b1) orderErrors++;
            @(negedge clk);
`else
            @(negedge clk);
            if (if_id_reg !== 8'(i) || if_id_valid !== 1'b1) orderErrors++;
`endif
            if (i == 254) begin
                checkCount++; if (pc !== 8'd255) $display("[TB] FAIL wrap_pc255: got %0d want 255", pc); else passCount++;
            end
        end
        checkCount++; if (orderErrors !== 0) $display("[TB] FAIL wrap_order: got %0d bad issues want 0", orderErrors); else passCount++;
        checkCount++; if (pc !== 8'd0) $display("[TB] FAIL wrap_pc0: got %0d want 0", pc); else passCount++;
    endtask

    task automatic test_async_reset();
        applyReset();
        stall = 1'b1;
        pushInstr(8'h11); pushInstr(8'h22); pushInstr(8'h33); pushInstr(8'h44); pushInstr(8'h55);
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        checkCount++; if (count !== 3'd3 || overflow !== 1'b1 || pc !== 8'd1) $display("[TB] FAIL areset_pre: got count=%0d ovf=%b pc=%0d want 3/1/1", count, overflow, pc); else passCount++;
        @(posedge clk);
        #3;
        load   = 1'b1;
        resetn = 1'b0;
        #1;
        checkCount++; if (if_id_reg !== 8'h00 || if_id_valid !== 1'b0 || pc !== 8'd0) $display("[TB] FAIL areset_out: got reg=%h valid=%b pc=%0d want 00/0/0", if_id_reg, if_id_valid, pc); else passCount++;
        checkCount++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) $display("[TB] FAIL areset_flags: got count=%0d empty=%b full=%b ovf=%b want 0/1/0/0", count, empty, full, overflow); else passCount++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkCount++; if (count !== 3'd1) $display("[TB] FAIL areset_heldkey: got count=%0d want 1", count); else passCount++;
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        resetn = 1'b0; load = 1'b0; stall = 1'b0; instr_in = 8'h00;
        test_reset();
        test_single_issue();
        test_fill_drain();
        test_overflow();
        test_held_load();
        test_pc_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
